// File: rtl/sr_decomp_pkg.sv
// Shared definitions for the SR decompression unit.
//   DATA_W    : beat width in bits
//   LANE_W    : decoded lane width in bits
//   NUM_LANES : decoded lanes per beat
//   CODE_W    : significant bits produced per lane by decode_byte()
package sr_decomp_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned LANE_W    = 16;
  localparam int unsigned NUM_LANES = DATA_W / LANE_W;
  localparam int unsigned CODE_W    = 4;

  // A payload byte keeps its sign-like top bit and the 3-bit code in b[3:1];
  // b[6:4] and b[0] carry no information for the decoded lane.
  function automatic logic [CODE_W-1:0] decode_byte(input logic [7:0] b);
    return {b[7], b[3:1]};
  endfunction

endpackage

// File: rtl/sr_skid_fifo.sv
// Depth-entry valid/ready buffer with registered storage.
//   clk      : rising-edge clock
//   rst_n    : synchronous reset, active-high
//   wdata_i  : write payload
//   wvalid_i : write request
//   wready_o : buffer accepts a write this cycle
//   rdata_o  : head entry
//   rvalid_o : buffer non-empty
//   rready_i : consumer takes the head entry this cycle
module sr_skid_fifo #(
  parameter int unsigned Width = 66,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] wdata_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic [Width-1:0] rdata_o,
  output logic             rvalid_o,
  input  logic             rready_i
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full;
  logic             push;
  logic             pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full     = (cnt_q == FullCnt);
  assign rvalid_o = (cnt_q != '0);
  // A full buffer still accepts when the head leaves in the same cycle.
  assign wready_o = !full || rready_i;
  assign push     = wvalid_i && wready_o;
  assign pop      = rvalid_o && rready_i;
  assign rdata_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      // When full, the write slot equals the head being read this cycle; the
      // read uses the old value and the new one lands at the edge.
      if (push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/sr_decomp_unit.sv
// SR decompression unit: decodes each payload byte of a beat into a lane and
// buffers the decoded beat, with its framing flags, in a skid FIFO.
//   clk     : rising-edge clock
//   rst_n   : synchronous reset, active-high
//   data_i  : compressed beat (low half payload, high half header/check)
//   valid_i : input beat valid
//   sop_i   : first beat of packet
//   eop_i   : last beat of packet
//   ready_o : input beat accepted this cycle
//   data_o  : decoded beat, NUM_LANES lanes of LANE_W bits
//   valid_o : output beat valid
//   sop_o   : sop of the output beat
//   eop_o   : eop of the output beat
//   ready_i : downstream accepts the output beat
module sr_decomp_unit #(
  parameter int unsigned DATA_W = sr_decomp_pkg::DATA_W,
  parameter int unsigned LANE_W = sr_decomp_pkg::LANE_W,
  parameter int unsigned FIFO_D = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              sop_i,
  input  logic              eop_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o,
  input  logic              ready_i
);

  import sr_decomp_pkg::*;

  localparam int unsigned NumLanes = DATA_W / LANE_W;
  localparam int unsigned PayW     = NumLanes * 8;

  logic [DATA_W-1:0] dec_data;
  logic [DATA_W+1:0] fifo_wdata;
  logic [DATA_W+1:0] fifo_rdata;
  logic              unused_hdr;

  // Header/check half never reaches the decoded lanes.
  assign unused_hdr = ^data_i[DATA_W-1:PayW];

  always_comb begin
    dec_data = '0;
    for (int j = 0; j < NumLanes; j++) begin
      dec_data[j*LANE_W +: CODE_W] = decode_byte(data_i[j*8 +: 8]);
    end
  end

  assign fifo_wdata = {sop_i, eop_i, dec_data};

  sr_skid_fifo #(
    .Width (DATA_W + 2),
    .Depth (FIFO_D)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wdata_i  (fifo_wdata),
    .wvalid_i (valid_i),
    .wready_o (ready_o),
    .rdata_o  (fifo_rdata),
    .rvalid_o (valid_o),
    .rready_i (ready_i)
  );

  assign sop_o  = fifo_rdata[DATA_W+1];
  assign eop_o  = fifo_rdata[DATA_W];
  assign data_o = fifo_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_sr_decomp_unit.sv
module tb_sr_decomp_unit;

  logic        clk;
  logic        rst_n;
  logic [63:0] data_i;
  logic        valid_i;
  logic        sop_i;
  logic        eop_i;
  logic        ready_o;
  logic [63:0] data_o;
  logic        valid_o;
  logic        sop_o;
  logic        eop_o;
  logic        ready_i;

  int checks = 0;
  int errors = 0;
  logic [65:0] sb[$];

  sr_decomp_unit #(
    .DATA_W (64),
    .LANE_W (16),
    .FIFO_D (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .sop_i   (sop_i),
    .eop_i   (eop_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .sop_o   (sop_o),
    .eop_o   (eop_o),
    .ready_i (ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode: each of the four low bytes b becomes 8*msb + (b/2 mod 8).
  function automatic logic [63:0] model(input logic [63:0] d);
    logic [63:0] r;
    int unsigned b;
    int unsigned v;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      b = int'((d >> (8 * j)) & 64'hFF);
      v = (b / 128) * 8 + (b / 2) % 8;
      r = r | (64'(v) << (16 * j));
    end
    return r;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%016h required=0x%016h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor/scoreboard: samples 1 time unit before each rising edge.
  initial begin
    logic [65:0] exp;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        sb.delete();
      end else begin
        chk("valid_o_vs_occupancy", 64'(valid_o), 64'(sb.size() != 0));
        chk("ready_o_vs_occupancy", 64'(ready_o), 64'((sb.size() < 2) || ready_i));
        if (valid_o && ready_i) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 64'(valid_o), 64'h0);
          end else begin
            exp = sb.pop_front();
            chk("out_data", data_o, exp[63:0]);
            chk("out_sop", 64'(sop_o), 64'(exp[65]));
            chk("out_eop", 64'(eop_o), 64'(exp[64]));
          end
        end
        if (valid_i && ready_o) sb.push_back({sop_i, eop_i, model(data_i)});
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic s, input logic e);
    bit acc;
    acc = 1'b0;
    valid_i = 1'b1;
    data_i  = d;
    sop_i   = s;
    eop_i   = e;
    for (int n = 0; n < 20 && !acc; n++) begin
      #4;
      acc = ready_o;
      @(negedge clk);
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'h1);
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  lb;
    int          n;
    rst_n   = 1'b1;
    data_i  = '0;
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid_o", 64'(valid_o), 64'h0);
    chk("rst_sop_o", 64'(sop_o), 64'h0);
    chk("rst_eop_o", 64'(eop_o), 64'h0);
    chk("rst_data_o", data_o, 64'h0);
    chk("rst_ready_o", 64'(ready_o), 64'h1);
    rst_n = 1'b0;

    // First beat after reset, header flag set in bit 63.
    send(64'h8000000001010101, 1'b1, 1'b0);
    chk("first_valid_o", 64'(valid_o), 64'h1);
    chk("first_data_o", data_o, 64'h0);
    chk("first_sop_o", 64'(sop_o), 64'h1);
    idle(3);

    // Two 8-beat packets, back to back.
    for (int k = 0; k < 16; k++) begin
      lb = (k < 8) ? 8'(2 * k + 1) : 8'(8'hF1 + 2 * (k - 8));
      d  = {$urandom, {4{lb}}};
      send(d, (k % 8) == 0, (k % 8) == 7);
    end
    idle(4);

    // Backpressure: buffer fills to 2 and holds its head stable.
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 64'h0404040405050505;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid_o", 64'(valid_o), 64'h1);
      chk("hold_data_o", data_o, 64'h0002000200020002);
    end
    chk("hold_ready_o", 64'(ready_o), 64'h0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    idle(4);

    // Full buffer with simultaneous push and pop.
    ready_i = 1'b0;
    send(64'h00000000_02020202, 1'b1, 1'b0);
    send(64'h00000000_84848484, 1'b0, 1'b0);
    chk("full_ready_o", 64'(ready_o), 64'h0);
    ready_i = 1'b1;
    send(64'h00000000_0E0E0E0E, 1'b0, 1'b1);
    chk("full_pp_valid_o", 64'(valid_o), 64'h1);
    chk("full_pp_data_o", data_o, model(64'h00000000_84848484));
    idle(5);

    // Reset with two beats buffered.
    ready_i = 1'b0;
    send(64'h11111111_22222222, 1'b1, 1'b0);
    send(64'h33333333_44444444, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid_o", 64'(valid_o), 64'h0);
    chk("midrst_ready_o", 64'(ready_o), 64'h1);
    rst_n   = 1'b0;
    ready_i = 1'b1;
    send(64'hfefefefeffffffff, 1'b0, 1'b0);
    chk("post_rst_data_o", data_o, 64'h000f000f000f000f);
    idle(3);

    // Random traffic.
    repeat (400) begin
      ready_i = ($urandom % 4) != 0;
      valid_i = $urandom % 2;
      data_i  = {$urandom, $urandom};
      sop_i   = $urandom % 2;
      eop_i   = $urandom % 2;
      @(negedge clk);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
